// File: rtl/life_pkg.sv
// Shared life-array geometry and writer FSM encoding.
// Display and memory blocks use the same geometry as the writer.
package life_pkg;

    localparam int LIFE_ROWS   = 4;
    localparam int LIFE_COLS   = 4;
    localparam int LIFE_ADDR_W = $clog2(LIFE_ROWS);

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } wr_state_t;

endpackage

// File: rtl/life_frame_writer_if.sv
// Row write port of the display memory.
// The writer is the master; the block memory is the slave.
interface life_frame_writer_if #(
    parameter int ADDR_W = 2,
    parameter int COLS   = 4
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [COLS-1:0]   mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/life_frame_writer.sv
// Snapshots each life generation and copies it into display memory one row per clock
// at the start of vertical blanking, so the displayed frame never tears.
module life_frame_writer
    import life_pkg::*;
#(
    parameter int ROWS   = LIFE_ROWS,
    parameter int COLS   = LIFE_COLS,
    parameter int ADDR_W = LIFE_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] alive,
    input  logic                 update,
    input  logic                 frame,
    life_frame_writer_if.master  mem,
    output logic                 busy,
    output logic                 copy_done,
    output logic                 dirty
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    wr_state_t            state_q, state_d;
    logic [ADDR_W-1:0]    row_q, row_d;
    logic [ROWS*COLS-1:0] staged_q, staged_d;
    logic [ROWS*COLS-1:0] active_q, active_d;
    logic                 dirty_q, dirty_d;

    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [COLS-1:0]      mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;
    logic                 copy_done_q, copy_done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            staged_q    <= '0;
            active_q    <= '0;
            dirty_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            copy_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            staged_q    <= staged_d;
            active_q    <= active_d;
            dirty_q     <= dirty_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            copy_done_q <= copy_done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        staged_d = staged_q;
        active_d = active_q;
        dirty_d  = dirty_q;

        if (update) begin
            staged_d = alive;
            dirty_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A same-cycle update bypasses staged so the newest generation goes out now.
                if (frame && (dirty_q || update)) begin
                    active_d = update ? alive : staged_q;
                    dirty_d  = 1'b0;
                    row_d    = '0;
                    state_d  = COPY;
                end
            end
            COPY: begin
                if (row_q == LAST_ROW) begin
                    state_d = IDLE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next-state values and registered, so they line up with state_q.
    always_comb begin
        mem_we_d    = (state_d == COPY);
        busy_d      = mem_we_d;
        mem_addr_d  = mem_we_d ? row_d : '0;
        mem_wdata_d = mem_we_d ? active_d[int'(row_d)*COLS +: COLS] : '0;
        copy_done_d = mem_we_d && (row_d == LAST_ROW);
    end

    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign copy_done     = copy_done_q;
    assign dirty         = dirty_q;

endmodule

// File: tb/tb_life_frame_writer.sv
// Directed bench for life_frame_writer: a vector table plus hand sequences
// for idle frames and reset during a copy.
module tb_life_frame_writer;
    import life_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alive;
    logic        update;
    logic        frame;
    logic        busy, copy_done, dirty;

    life_frame_writer_if #(.ADDR_W(2), .COLS(4)) mem_if ();

    life_frame_writer #(.ROWS(4), .COLS(4), .ADDR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .alive     (alive),
        .update    (update),
        .frame     (frame),
        .mem       (mem_if),
        .busy      (busy),
        .copy_done (copy_done),
        .dirty     (dirty)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst, upd, frm;
        logic [15:0] al;
        logic [9:0]  exp;   // {we, addr[1:0], wdata[3:0], busy, done, dirty}
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;

    function automatic vec_t mk(string n, logic rs, logic up, logic fr, logic [15:0] al,
                                logic we, logic [1:0] ad, logic [3:0] wd,
                                logic bz, logic dn, logic dt);
        vec_t v;
        v.name = n; v.rst = rs; v.upd = up; v.frm = fr; v.al = al;
        v.exp  = {we, ad, wd, bz, dn, dt};
        return v;
    endfunction

    function automatic logic [9:0] observed();
        return {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, busy, copy_done, dirty};
    endfunction

    task automatic step(input logic rs, input logic up, input logic fr, input logic [15:0] al);
        @(negedge clk);
        reset = rs; update = up; frame = fr; alive = al;
        @(posedge clk);
        #1;
        if (mem_if.mem_we === 1'b1) writes++;
    endtask

    task automatic check(input string n, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {we,addr,wdata,busy,done,dirty}=%b required %b", n, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; update = 1'b0; frame = 1'b0; alive = '0;

        // reset, then 0x3300 copied five cycles after its update
        vq.push_back(mk("reset",      1,0,0,16'h0000, 0,2'd0,4'h0, 0,0,0));
        vq.push_back(mk("upd3300",    0,1,0,16'h3300, 0,2'd0,4'h0, 0,0,1));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk("wait3300", 0,0,0,16'h0000, 0,2'd0,4'h0, 0,0,1));
        vq.push_back(mk("3300_r0",    0,0,1,16'h0000, 1,2'd0,4'h0, 1,0,0));
        vq.push_back(mk("3300_r1",    0,0,0,16'h0000, 1,2'd1,4'h0, 1,0,0));
        vq.push_back(mk("3300_r2",    0,0,0,16'h0000, 1,2'd2,4'h3, 1,0,0));
        vq.push_back(mk("3300_r3",    0,0,0,16'h0000, 1,2'd3,4'h3, 1,1,0));
        vq.push_back(mk("3300_end",   0,0,0,16'h0000, 0,2'd0,4'h0, 0,0,0));
        // update coincident with frame
        vq.push_back(mk("6186_r0",    0,1,1,16'h6186, 1,2'd0,4'h6, 1,0,0));
        vq.push_back(mk("6186_r1",    0,0,0,16'h0000, 1,2'd1,4'h8, 1,0,0));
        vq.push_back(mk("6186_r2",    0,0,0,16'h0000, 1,2'd2,4'h1, 1,0,0));
        vq.push_back(mk("6186_r3",    0,0,0,16'h0000, 1,2'd3,4'h6, 1,1,0));
        vq.push_back(mk("6186_end",   0,0,0,16'h0000, 0,2'd0,4'h0, 0,0,0));
        // update mid-copy must not disturb the active snapshot
        vq.push_back(mk("upd33cc",    0,1,0,16'h33CC, 0,2'd0,4'h0, 0,0,1));
        vq.push_back(mk("33cc_r0",    0,0,1,16'h0000, 1,2'd0,4'hC, 1,0,0));
        vq.push_back(mk("33cc_r1",    0,0,0,16'h0000, 1,2'd1,4'hC, 1,0,0));
        vq.push_back(mk("33cc_r2upd", 0,1,0,16'h0700, 1,2'd2,4'h3, 1,0,1));
        vq.push_back(mk("33cc_r3",    0,0,0,16'h0000, 1,2'd3,4'h3, 1,1,1));
        vq.push_back(mk("33cc_end",   0,0,0,16'h0000, 0,2'd0,4'h0, 0,0,1));
        vq.push_back(mk("0700_r0",    0,0,1,16'h0000, 1,2'd0,4'h0, 1,0,0));
        vq.push_back(mk("0700_r1",    0,0,0,16'h0000, 1,2'd1,4'h0, 1,0,0));
        vq.push_back(mk("0700_r2",    0,0,0,16'h0000, 1,2'd2,4'h7, 1,0,0));
        vq.push_back(mk("0700_r3",    0,0,0,16'h0000, 1,2'd3,4'h0, 1,1,0));
        vq.push_back(mk("0700_end",   0,0,0,16'h0000, 0,2'd0,4'h0, 0,0,0));
        // frames during a copy and a frame with nothing pending
        vq.push_back(mk("upd1234",    0,1,0,16'h1234, 0,2'd0,4'h0, 0,0,1));
        vq.push_back(mk("1234_r0",    0,0,1,16'h0000, 1,2'd0,4'h4, 1,0,0));
        vq.push_back(mk("1234_r1frm", 0,0,1,16'h0000, 1,2'd1,4'h3, 1,0,0));
        vq.push_back(mk("1234_r2frm", 0,0,1,16'h0000, 1,2'd2,4'h2, 1,0,0));
        vq.push_back(mk("1234_r3",    0,0,0,16'h0000, 1,2'd3,4'h1, 1,1,0));
        vq.push_back(mk("1234_idlefr",0,0,1,16'h0000, 0,2'd0,4'h0, 0,0,0));
        vq.push_back(mk("1234_quiet", 0,0,0,16'h0000, 0,2'd0,4'h0, 0,0,0));

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].upd, vq[i].frm, vq[i].al);
            check($sformatf("%s#%0d", vq[i].name, i), observed(), vq[i].exp);
        end

        // frame with no pending data, then a 10-cycle quiet watch
        writes = 0;
        step(0, 0, 1, 16'h0000);
        check("nopend_frame", {mem_if.mem_we, busy, dirty}, 3'b000);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 16'h0000);
            check($sformatf("nopend_quiet%0d", i), {mem_if.mem_we, busy, dirty}, 3'b000);
        end
        check("nopend_writes", 10'(writes), 10'd0);

        // reset two cycles into a copy aborts it
        writes = 0;
        step(0, 1, 0, 16'hA5F0);
        step(0, 0, 1, 16'h0000);
        check("abort_r0", observed(), {1'b1, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0});
        step(0, 0, 0, 16'h0000);
        check("abort_r1", observed(), {1'b1, 2'd1, 4'hF, 1'b1, 1'b0, 1'b0});
        step(1, 0, 0, 16'h0000);
        check("abort_reset", observed(), 10'b0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0000);
        step(0, 0, 1, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 16'h0000);
            check($sformatf("abort_post%0d", i), {mem_if.mem_we, busy, copy_done, dirty}, 4'b0000);
        end
        check("abort_writes", 10'(writes), 10'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_frame_writer.md
Name: life_frame_writer

Overview:
- Writer side of the display memory. The Display/VGA path only reads cell rows from this memory; this block is what fills it.
- Captures each new life-array generation as a snapshot. At the next `frame` pulse (start of vertical blanking from VESADriver), copies the snapshot into the memory write port one row per clock.
- Sits between life_array_4x4 (source of `alive`) and the block memory's write port. The displayed image therefore never tears mid-frame.

Parameters:
- ROWS, 4, number of cell rows in the array (must be ≥ 2).
- COLS, 4, cells per row; the memory data width.
- ADDR_W, 2, row address width; must equal clog2(ROWS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- alive  in  ROWS*COLS  flattened cell states from the array; row r = alive[r*COLS +: COLS].
- update  in  1  single-cycle pulse: `alive` holds a new generation this cycle.
- frame  in  1  single-cycle pulse at the start of vertical blanking.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  row address being written.
- mem_wdata  out  COLS  row data being written.
- busy  out  1  high while a copy is in progress.
- copy_done  out  1  single-cycle pulse coincident with the last row write.
- dirty  out  1  a captured generation is waiting to be copied.

Behaviour:
- Reset is synchronous, active-high. Every output is 0 on the cycle after reset is sampled high.
- Reset also clears the staged and active snapshot registers and the row counter, and returns the FSM to IDLE.
- Reset during COPY aborts the copy immediately; no further writes occur and partially written rows are left as they are.
- Two registers, both ROWS*COLS bits wide:
  - `staged`: on `update`, load staged <= alive and set dirty=1.
  - `active`: frozen copy being written to memory.
- FSM states: IDLE, COPY.
- IDLE:
  - if frame=1 and (dirty=1 or update=1): active <= (update ? alive : staged); clear dirty; row <= 0; go to COPY.
  - otherwise stay in IDLE; frame with no pending data is ignored.
- COPY, in the same cycle:
  - mem_we=1, mem_addr=row, mem_wdata=active[row*COLS +: COLS], busy=1.
  - if row==ROWS-1: copy_done=1 and go to IDLE; else row <= row+1.
- COPY outputs are registered. A frame accepted at cycle N gives writes at cycles N+1 .. N+ROWS, with copy_done at N+ROWS. busy is high exactly at N+1 .. N+ROWS.
- In IDLE: mem_we=0, busy=0, copy_done=0, and mem_addr/mem_wdata are held at 0.
- `update` during COPY: loads `staged` and sets dirty=1. The `active` register is not disturbed, so the current copy completes with its original data.
- `update` in the same cycle a frame is accepted: the new `alive` is copied this frame and dirty ends at 0.
- `frame` during COPY is ignored and has no queuing effect.
- Multiple updates between frames: only the latest generation is copied; earlier ones are dropped by design.
- The row counter never wraps mid-copy. It is reloaded to 0 on every accepted frame.

Decomposition:
- Shared package life_pkg: ROWS/COLS defaults, the ADDR_W derivation, and the FSM state encoding (IDLE=0, COPY=1), also used by Display and the memory.
- No sub-module is needed. The snapshot registers plus FSM form a single module; optionally, the row counter can be split out as life_row_counter (load-to-0 and increment, terminal-count flag).

Test Plan:
- Reset, then update with alive=16'h3300, then frame 5 cycles later → writes (addr,data) = (0,0x0),(1,0x0),(2,0x3),(3,0x3) on 4 consecutive cycles; copy_done on the 4th; dirty 1→0 at frame acceptance.
- Frame with no prior update → no mem_we for 10 cycles; busy and dirty stay 0.
- Update (alive=16'h6186) in the same cycle as frame → writes 0x6,0x8,0x1,0x6 at N+1..N+4; dirty=0 afterwards.
- During a copy of 16'h33CC, update with 16'h0700 at N+2 → copy still writes 0xC,0xC,0x3,0x3; dirty=1. The next frame writes 0x0,0x0,0x7,0x0.
- Two frames during one copy, plus a frame while dirty=0 → no extra or restarted writes; exactly 4 writes in total.
- Assert reset at N+2 of a copy → mem_we=0, busy=0, copy_done=0 on the next cycle; no further writes; a subsequent frame without an update produces no writes.
